// File: rtl/spi_reg_bank_if.sv
// Bus between the spi_slave transfer engine (master) and the register bank (slave).
interface spi_reg_bank_if #(
    parameter int DW = 32,
    parameter int AW = 7
);
    logic          spi_we;
    logic          spi_re;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdat;
    logic [DW-1:0] rdat;

    // spi_we/spi_re act as the valid of a transfer: a level pulse, asynchronous to
    // clk, with addr (and wdat for writes) stable for as long as it is high. There is
    // no ready: the slave accepts every strobe once. rdat holds the last read result.
    modport master (output spi_we, spi_re, addr, wdat, input rdat);
    modport slave  (input spi_we, spi_re, addr, wdat, output rdat);
endinterface

// File: rtl/spi_reg_bank.sv
// SPI-facing register bank: synchronised strobes, NREG RW registers, a status word
// and write/read/error event counters.
module spi_reg_bank #(
    parameter int            DW          = 32,
    parameter int            AW          = 7,
    parameter int            NREG        = 4,
    parameter logic [AW-1:0] BASE        = 7'h70,
    parameter logic [DW-1:0] RESET_VAL   = '0,
    parameter int            SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    spi_reg_bank_if.slave      bus,
    input  logic [DW-1:0]      status_in,
    output logic [NREG*DW-1:0] reg_out,
    output logic [NREG-1:0]    wr_strobe,
    output logic               err
);
    localparam logic [AW-1:0] A_STATUS = AW'(7'h7C);
    localparam logic [AW-1:0] A_WCNT   = AW'(7'h7D);
    localparam logic [AW-1:0] A_RCNT   = AW'(7'h7E);
    localparam logic [AW-1:0] A_ECNT   = AW'(7'h7F);
    localparam logic [AW-1:0] NREG_A   = AW'(NREG);

    logic [SYNC_STAGES-1:0] we_sync, re_sync;
    logic                   we_q_d, re_q_d;
    logic                   we_en, re_en;

    logic [DW-1:0] regs [NREG];
    logic [DW-1:0] wr_cnt, rd_cnt, err_cnt;
    logic [DW-1:0] wr_cnt_nxt, rd_cnt_nxt, err_cnt_nxt;
    logic [DW-1:0] rd_val;

    logic [AW-1:0] off;
    logic          is_rw, is_status, is_wcnt, is_rcnt, is_ecnt, is_cnt;
    logic          w_ill, r_ill;

    always_ff @(posedge clk) begin
        if (reset) begin
            we_sync <= '0;
            re_sync <= '0;
            we_q_d  <= 1'b0;
            re_q_d  <= 1'b0;
        end else begin
            we_sync <= {we_sync[SYNC_STAGES-2:0], bus.spi_we};
            re_sync <= {re_sync[SYNC_STAGES-2:0], bus.spi_re};
            we_q_d  <= we_sync[SYNC_STAGES-1];
            re_q_d  <= re_sync[SYNC_STAGES-1];
        end
    end

    // Rising-edge detect: one enable per strobe however long it is held.
    assign we_en = we_sync[SYNC_STAGES-1] & ~we_q_d;
    assign re_en = re_sync[SYNC_STAGES-1] & ~re_q_d;

    // Addresses below BASE wrap to a large offset, so one compare covers both bounds.
    assign off       = bus.addr - BASE;
    assign is_rw     = (off < NREG_A);
    assign is_status = (bus.addr == A_STATUS);
    assign is_wcnt   = (bus.addr == A_WCNT);
    assign is_rcnt   = (bus.addr == A_RCNT);
    assign is_ecnt   = (bus.addr == A_ECNT);
    assign is_cnt    = is_wcnt | is_rcnt | is_ecnt;

    assign w_ill = we_en & ~(is_rw | is_cnt);
    assign r_ill = re_en & ~(is_rw | is_status | is_cnt);

    always_comb begin
        rd_val = '0;
        if (is_rw) begin
            for (int i = 0; i < NREG; i++) begin
                if (off == AW'(i)) rd_val = regs[i];
            end
        end else if (is_status) begin
            rd_val = status_in;
        end else if (is_wcnt) begin
            rd_val = wr_cnt;
        end else if (is_rcnt) begin
            rd_val = rd_cnt;
        end else if (is_ecnt) begin
            rd_val = err_cnt;
        end
    end

    // A clear from a counter write overrides any increment landing in the same cycle.
    always_comb begin
        wr_cnt_nxt  = wr_cnt + DW'(we_en & (is_rw | is_rcnt | is_ecnt));
        rd_cnt_nxt  = rd_cnt + DW'(re_en & ~r_ill);
        err_cnt_nxt = err_cnt + DW'(w_ill) + DW'(r_ill);
        if (we_en && is_wcnt) wr_cnt_nxt  = '0;
        if (we_en && is_rcnt) rd_cnt_nxt  = '0;
        if (we_en && is_ecnt) err_cnt_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= RESET_VAL;
            bus.rdat  <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            err_cnt   <= '0;
            wr_strobe <= '0;
            err       <= 1'b0;
        end else begin
            wr_strobe <= '0;
            for (int i = 0; i < NREG; i++) begin
                if (we_en && is_rw && off == AW'(i)) begin
                    regs[i]      <= bus.wdat;
                    wr_strobe[i] <= 1'b1;
                end
            end
            if (re_en) bus.rdat <= rd_val;
            wr_cnt  <= wr_cnt_nxt;
            rd_cnt  <= rd_cnt_nxt;
            err_cnt <= err_cnt_nxt;
            err     <= w_ill | r_ill;
        end
    end

    for (genvar gi = 0; gi < NREG; gi++) begin : g_out
        assign reg_out[gi*DW +: DW] = regs[gi];
    end
endmodule
